csla_pipe_adder: RTL and testbench



---
 rtl/csla_pipe_adder.sv | 125 ++++++++++++
 tb/tb_csla_pipe_adder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/csla_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready handshake.
// Stage 1 forms per-block candidate sums, stage 2 resolves the block carry chain.
module csla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NB = WIDTH / BLK;

  // Stage 1 state: block candidates and operand sign bits
  logic             s1_valid_q;
  logic [WIDTH-1:0] cand0_q, cand0_d;
  logic [WIDTH-1:0] cand1_q, cand1_d;
  logic [NB-1:0]    cy0_q, cy0_d;
  logic [NB-1:0]    cy1_q, cy1_d;
  logic             a_msb_q, b_msb_q;

  // Stage 2 state: resolved result
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_eff;
  logic [BLK:0]     t0, t1;
  logic             cin;
  logic             s2_en_c, s1_en_c, accept_c;

  // Pipeline advance: a stage moves when it is empty or its consumer moves
  assign s2_en_c  = !out_valid_q || out_ready;
  assign s1_en_c  = !s1_valid_q || s2_en_c;
  assign accept_c = in_valid && s1_en_c;
  assign in_ready = s1_en_c;

  // Per-block ripple sums for cin=0 and cin=1; block 0 uses the real carry-in
  // in both slots so the select chain can start from a fixed 0.
  always_comb begin
    b_eff   = sub ? ~b : b;
    cand0_d = '0;
    cand1_d = '0;
    cy0_d   = '0;
    cy1_d   = '0;
    t0      = '0;
    t1      = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      t0 = {1'b0, a[k*BLK +: BLK]} + {1'b0, b_eff[k*BLK +: BLK]}
         + {BLK'(0), (k == 0) ? sub : 1'b0};
      t1 = {1'b0, a[k*BLK +: BLK]} + {1'b0, b_eff[k*BLK +: BLK]}
         + {BLK'(0), (k == 0) ? sub : 1'b1};
      cand0_d[k*BLK +: BLK] = t0[BLK-1:0];
      cand1_d[k*BLK +: BLK] = t1[BLK-1:0];
      cy0_d[k]              = t0[BLK];
      cy1_d[k]              = t1[BLK];
    end
  end

  // Stage 1 register: load on accept, otherwise drain when downstream moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      cand0_q    <= '0;
      cand1_q    <= '0;
      cy0_q      <= '0;
      cy1_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
    end else if (accept_c) begin
      s1_valid_q <= 1'b1;
      cand0_q    <= cand0_d;
      cand1_q    <= cand1_d;
      cy0_q      <= cy0_d;
      cy1_q      <= cy1_d;
      a_msb_q    <= a[WIDTH-1];
      b_msb_q    <= b_eff[WIDTH-1];
    end else if (s1_en_c) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Select chain: each block's carry picks the next block's candidate
  always_comb begin
    sum_d = '0;
    cin   = 1'b0;
    for (int unsigned k = 0; k < NB; k++) begin
      sum_d[k*BLK +: BLK] = cin ? cand1_q[k*BLK +: BLK] : cand0_q[k*BLK +: BLK];
      cin                 = cin ? cy1_q[k] : cy0_q[k];
    end
    cout_d = cin;
    ovf_d  = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
  end

  // Stage 2 register: holds result steady while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (s2_en_c) begin
      out_valid_q <= s1_valid_q;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csla_pipe_adder.sv
// Self-checking bench for csla_pipe_adder: directed vectors, backpressure,
// mid-flight reset, a short randomized stream, and the single-block case.
module tb_csla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        in_valid8, in_ready8, sub8, out_valid8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] exp_v;

  always #5 clk = ~clk;

  csla_pipe_adder #(.WIDTH(16), .BLK(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  csla_pipe_adder #(.WIDTH(8), .BLK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(1'b1),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: signed range check for ovf, magnitude compare for cout
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s);
    int          sx, sy, r;
    logic        ov, c;
    logic [15:0] sm;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = s ? sx - sy : sx + sy;
    ov = (r > 32767) || (r < -32768);
    c  = s ? (x >= y) : ((32'(x) + 32'(y)) > 32'h0000_FFFF);
    sm = s ? x - y : x + y;
    return {c, ov, sm};
  endfunction

  // One isolated operation with out_ready high; result appears after the second edge
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic s, input logic [15:0] e_sum, input logic e_c,
                        input logic e_o);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    sub       = s;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    cyc();
    check({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, ".sum"}, 64'(sum), 64'(e_sum));
    check({tag, ".cout_ovf"}, 64'({cout, ovf}), 64'({e_c, e_o}));
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    in_valid8 = 1'b0;
    a8        = '0;
    b8        = '0;
    sub8      = 1'b0;

    // Asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.sum", 64'(sum), 64'(0));
    check("rst.cout_ovf", 64'({cout, ovf}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    check("rst.in_ready", 64'(in_ready), 64'(1));
    check("rst.no_output", 64'(out_valid), 64'(0));

    // Directed arithmetic vectors
    run_op("add_xblk", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("add_alt",  16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0);
    cyc();
    check("drain.idle", 64'(out_valid), 64'(0));

    // Backpressure: 1+1, 2+2, 3+3 with out_ready low for three edges
    out_ready = 1'b0;
    sub       = 1'b0;
    in_valid  = 1'b1;
    a = 16'd1; b = 16'd1;
    cyc();
    a = 16'd2; b = 16'd2;
    cyc();
    a = 16'd3; b = 16'd3;
    check("bp.in_ready_low", 64'(in_ready), 64'(0));
    check("bp.first", 64'({out_valid, sum}), 64'({1'b1, 16'h0002}));
    cyc();
    check("bp.hold_ready", 64'(in_ready), 64'(0));
    check("bp.hold_sum", 64'({out_valid, sum}), 64'({1'b1, 16'h0002}));
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 64'(in_ready), 64'(1));
    cyc();
    in_valid = 1'b0;
    check("bp.second", 64'({out_valid, sum}), 64'({1'b1, 16'h0004}));
    cyc();
    check("bp.third", 64'({out_valid, sum}), 64'({1'b1, 16'h0006}));
    cyc();
    check("bp.empty", 64'(out_valid), 64'(0));

    // Reset while two transactions are in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'd9; b = 16'd1;
    cyc();
    a = 16'd20; b = 16'd5;
    cyc();
    in_valid = 1'b0;
    check("rst2.pre_valid", 64'({out_valid, sum}), 64'({1'b1, 16'h000A}));
    #2 rst_n = 1'b0;
    #1;
    check("rst2.async_valid", 64'(out_valid), 64'(0));
    check("rst2.async_sum", 64'(sum), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst2.in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst2.no_stale", 64'(out_valid), 64'(0));
    end

    // Randomized stream with random backpressure, in-order scoreboard
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rnd.unexpected", 64'(out_valid), 64'(0));
        else begin
          exp_v = exp_q.pop_front();
          check("rnd.result", 64'({cout, ovf, sum}), 64'(exp_v));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid && exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        check("rnd.drain", 64'({cout, ovf, sum}), 64'(exp_v));
      end
      cyc();
    end
    check("rnd.all_drained", 64'(exp_q.size()), 64'(0));

    // Single-block configuration (WIDTH == BLK)
    in_valid8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0;
    cyc();
    in_valid8 = 1'b1; a8 = 8'h00; b8 = 8'h01; sub8 = 1'b1;
    cyc();
    in_valid8 = 1'b0;
    check("w8.add_ovf", 64'({out_valid8, cout8, ovf8, sum8}), 64'({3'b101, 8'h80}));
    cyc();
    check("w8.sub_borrow", 64'({out_valid8, cout8, ovf8, sum8}), 64'({3'b100, 8'hFF}));
    check("w8.in_ready", 64'(in_ready8), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
